// File: rtl/pulse_measure.sv
// Measures high width and rise-to-rise period of an asynchronous pulse train and tracks lock.
// Results appear 3 cycles after the din rise that closes a period; no backpressure, strobe is fire-and-forget.
module pulse_measure #(
  parameter int CNT_W      = 8,
  parameter int EXP_HIGH   = 5,
  parameter int EXP_PERIOD = 17,
  parameter int LOCK_N     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             clear,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] period_len,
  output logic             meas_valid,
  output logic             match,
  output logic             lock,
  output logic             err_ovf
);

  localparam int LCK_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] EXP_P    = CNT_W'(EXP_PERIOD);
  localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_N);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  logic             s1_q, s2_q, s3_q;
  logic [1:0]       vld_q;
  logic             armed_q;
  logic             rise, fall, hit;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] period_len_q, period_len_d;
  logic             meas_valid_q, meas_valid_d;
  logic             match_q, match_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;

  // armed_q blocks a rise until din has been seen low after reset, so a level held through reset is not an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~s2_q);
    end
  end

  assign rise = armed_q & s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
  assign hit  = (hi_cap_q == EXP_H) && (cnt_q == EXP_P);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_cap_d     = hi_cap_q;
    lock_cnt_d   = lock_cnt_q;
    high_len_d   = high_len_q;
    period_len_d = period_len_q;
    meas_valid_d = 1'b0;
    match_d      = match_q;
    lock_d       = lock_q;
    err_d        = err_q;
    if (clear) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      hi_cap_d     = '0;
      lock_cnt_d   = '0;
      high_len_d   = '0;
      period_len_d = '0;
      match_d      = 1'b0;
      lock_d       = 1'b0;
      err_d        = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_HIGH, ST_LOW: begin
          // Saturation wins over a coincident edge so the counter can never wrap
          if (cnt_q == CNT_MAX) begin
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            lock_cnt_d = '0;
            lock_d     = 1'b0;
          end else if (state_q == ST_HIGH && fall) begin
            state_d  = ST_LOW;
            hi_cap_d = cnt_q;
            cnt_d    = cnt_q + CNT_W'(1);
          end else if (state_q == ST_LOW && rise) begin
            state_d      = ST_HIGH;
            cnt_d        = CNT_W'(1);
            high_len_d   = hi_cap_q;
            period_len_d = cnt_q;
            match_d      = hit;
            meas_valid_d = 1'b1;
            if (!hit)
              lock_cnt_d = '0;
            else if (lock_cnt_q != LOCK_MAX)
              lock_cnt_d = lock_cnt_q + LCK_W'(1);
            lock_d = (lock_cnt_d == LOCK_MAX);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_cap_q     <= '0;
      lock_cnt_q   <= '0;
      high_len_q   <= '0;
      period_len_q <= '0;
      meas_valid_q <= 1'b0;
      match_q      <= 1'b0;
      lock_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_cap_q     <= hi_cap_d;
      lock_cnt_q   <= lock_cnt_d;
      high_len_q   <= high_len_d;
      period_len_q <= period_len_d;
      meas_valid_q <= meas_valid_d;
      match_q      <= match_d;
      lock_q       <= lock_d;
      err_q        <= err_d;
    end
  end

  assign high_len   = high_len_q;
  assign period_len = period_len_q;
  assign meas_valid = meas_valid_q;
  assign match      = match_q;
  assign lock       = lock_q;
  assign err_ovf    = err_q;

endmodule

// File: tb/tb_pulse_measure.sv
// Bench for pulse_measure: random and directed pulse trains against an event-level reference model.
module tb_pulse_measure;

  localparam int CNT_W = 8;
  localparam int OVF_AT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             din = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] high_len, period_len;
  logic             meas_valid, match, lock, err_ovf;

  always #5 clk = ~clk;

  pulse_measure #(.CNT_W(CNT_W), .EXP_HIGH(5), .EXP_PERIOD(17), .LOCK_N(3)) dut (
    .clk(clk), .reset(reset), .din(din), .clear(clear),
    .high_len(high_len), .period_len(period_len), .meas_valid(meas_valid),
    .match(match), .lock(lock), .err_ovf(err_ovf)
  );

  typedef struct {
    int hi;
    int per;
    bit mt;
    bit lk;
    bit er;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state, in units of clock edges and sampled din history
  int edge_n = 0;
  int nrel;
  int phase;    // 0 waiting for first rise, 1 high phase, 2 low phase
  int rise_e;
  int hi_m;
  int lockc;
  bit err_m;
  bit armed_m;
  bit h1, h2, h3;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    phase = 0; lockc = 0; err_m = 0; armed_m = 0;
    h1 = 0; h2 = 0; h3 = 0; nrel = 0;
  endtask

  task automatic publish(input int hi, input int per);
    exp_t e;
    bit   m;
    m = (hi == 5) && (per == 17);
    if (!m) lockc = 0;
    else if (lockc < 3) lockc++;
    e.hi = hi; e.per = per; e.mt = m; e.lk = (lockc == 3); e.er = err_m;
    exp_q.push_back(e);
  endtask

  // Called once per rising edge with the din/clear values that edge sampled
  task automatic model_edge(input bit d, input bit c);
    bit cur, prev, rs, fl;
    int el;
    edge_n++;
    nrel++;
    cur  = h2;  // din as seen after two synchronizer stages
    prev = h3;
    rs   = armed_m && cur && !prev;
    fl   = !cur && prev;
    if (c) begin
      phase = 0; lockc = 0; err_m = 0;
    end else if (phase != 0) begin
      el = edge_n - rise_e;
      if (el == OVF_AT) begin
        err_m = 1; phase = 0; lockc = 0;
      end else if (phase == 1 && fl) begin
        hi_m = el; phase = 2;
      end else if (phase == 2 && rs) begin
        publish(hi_m, el);
        rise_e = edge_n; phase = 1;
      end
    end else if (rs) begin
      phase = 1; rise_e = edge_n;
    end
    if (nrel >= 3 && !cur) armed_m = 1;
    h3 = h2; h2 = h1; h1 = d;
  endtask

  // Starts and ends at a falling edge
  task automatic tick(input bit d, input bit c);
    din = d;
    clear = c;
    @(posedge clk);
    model_edge(d, c);
    @(negedge clk);
  endtask

  task automatic period(input int h, input int l);
    repeat (h) tick(1'b1, 1'b0);
    repeat (l) tick(1'b0, 1'b0);
  endtask

  task automatic rand_period(input int h, input int l);
    repeat (h) tick(1'b1, $urandom_range(0, 299) == 0);
    repeat (l) tick(1'b0, $urandom_range(0, 299) == 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".high_len"}, int'(high_len), 0);
    chk({tag, ".period_len"}, int'(period_len), 0);
    chk({tag, ".meas_valid"}, int'(meas_valid), 0);
    chk({tag, ".match"}, int'(match), 0);
    chk({tag, ".lock"}, int'(lock), 0);
    chk({tag, ".err_ovf"}, int'(err_ovf), 0);
  endtask

  task automatic do_reset(input bit dlev);
    #1;
    reset = 1'b1;
    din   = dlev;
    clear = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && meas_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL strobe: unexpected meas_valid with high_len %0d period_len %0d, expected no strobe (t=%0t)",
                 high_len, period_len, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb.high_len", int'(high_len), e.hi);
        chk("sb.period_len", int'(period_len), e.per);
        chk("sb.match", int'(match), int'(e.mt));
        chk("sb.lock", int'(lock), int'(e.lk));
        chk("sb.err_ovf", int'(err_ovf), int'(e.er));
      end
    end
  end

  initial begin
    int h, l;
    model_reset();
    do_reset(1'b0);
    repeat (5) tick(1'b0, 1'b0);

    // Nominal 5/12 train until locked
    repeat (4) period(5, 12);
    chk("nom.high_len", int'(high_len), 5);
    chk("nom.period_len", int'(period_len), 17);
    chk("nom.match", int'(match), 1);
    chk("nom.lock", int'(lock), 1);

    // One 6/11 period breaks lock, then relock
    period(6, 11);
    repeat (3) tick(1'b1, 1'b0);
    chk("bad.high_len", int'(high_len), 6);
    chk("bad.period_len", int'(period_len), 17);
    chk("bad.match", int'(match), 0);
    chk("bad.lock", int'(lock), 0);
    repeat (2) tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    repeat (3) period(5, 12);
    chk("relock.lock", int'(lock), 1);

    // Long high phase saturates the counter
    repeat (300) tick(1'b1, 1'b0);
    chk("ovf.err_ovf", int'(err_ovf), 1);
    chk("ovf.lock", int'(lock), 0);
    repeat (12) tick(1'b0, 1'b0);
    repeat (3) period(5, 12);
    chk("ovf.sticky", int'(err_ovf), 1);
    chk("ovf.resume_high", int'(high_len), 5);

    // Clear coincident with a detected rise in the low phase
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk_zero("clear");
    repeat (2) tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    repeat (2) period(5, 12);

    // Single-cycle pulses
    repeat (3) period(1, 16);
    chk("narrow.high_len", int'(high_len), 1);
    chk("narrow.period_len", int'(period_len), 17);
    chk("narrow.match", int'(match), 0);

    // Reset a few cycles into a high phase, din held high through release
    repeat (4) period(5, 12);
    repeat (5) tick(1'b1, 1'b0);
    do_reset(1'b1);
    repeat (10) tick(1'b1, 1'b0);
    chk("rel.no_strobe_high", int'(high_len), 0);
    repeat (12) tick(1'b0, 1'b0);
    repeat (3) period(5, 12);
    chk("rel.high_len", int'(high_len), 5);
    chk("rel.period_len", int'(period_len), 17);

    // Randomized trains with occasional clears
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        h = 5; l = 12;
      end else begin
        h = $urandom_range(1, 10); l = $urandom_range(1, 25);
      end
      rand_period(h, l);
    end

    repeat (6) tick(1'b0, 1'b0);
    chk("pending_strobes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
